// File: rtl/ram_sweep_engine.sv
// ram_sweep_engine: sweeps an inclusive address range of a single-port
// synchronous RAM, either filling it (constant or incrementing pattern) or
// verifying it against the same patterns and counting miscompares.
//
// Control handshake: start is a single-cycle request that is only sampled
// while the engine is idle (busy==0 and done==0); there is no ready signal.
// busy is high for the whole sweep and done pulses for exactly one cycle when
// the sweep (or a rejected request) completes. Status outputs hold until the
// next accepted start.
module ram_sweep_engine #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q;
  logic                  incr_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] pat_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  we_q;
  logic                  re_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  range_err_q;
  logic                  mismatch_q;
  logic [CNT_WIDTH-1:0]  err_count_q;
  logic [ADDR_WIDTH-1:0] first_err_q;
  // Compare pipeline: expected word and address of the read issued last cycle.
  logic                  cmp_v_q;
  logic [DATA_WIDTH-1:0] exp_data_q;
  logic [ADDR_WIDTH-1:0] exp_addr_q;

  logic [DATA_WIDTH-1:0] pat_d;
  logic                  last_addr;
  logic                  miscompare;
  logic                  range_bad;

  // Next pattern word, end-of-range detect, compare result and range check.
  always_comb begin
    pat_d      = pat_q + DATA_WIDTH'(incr_q);
    last_addr  = (addr_q == end_q);
    miscompare = cmp_v_q && (mem_rdata != exp_data_q);
    range_bad  = (start_addr > end_addr) || ({1'b0, end_addr} >= DEPTH_C);
  end

  // Sweep FSM with registered RAM-side and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      incr_q      <= 1'b0;
      end_q       <= '0;
      addr_q      <= '0;
      pat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wdata_q     <= '0;
      range_err_q <= 1'b0;
      mismatch_q  <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
      cmp_v_q     <= 1'b0;
      exp_data_q  <= '0;
      exp_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            incr_q      <= mode[0];
            end_q       <= end_addr;
            range_err_q <= 1'b0;
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            cmp_v_q     <= 1'b0;
            if (range_bad) begin
              range_err_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              addr_q <= start_addr;
              pat_q  <= fill_value;
              busy_q <= 1'b1;
              if (!mode[1]) begin
                we_q    <= 1'b1;
                wdata_q <= fill_value;
                state_q <= ST_FILL;
              end else begin
                re_q    <= 1'b1;
                state_q <= ST_VERIFY;
              end
            end
          end
        end
        ST_FILL: begin
          if (last_addr) begin
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            pat_q   <= pat_d;
            wdata_q <= pat_d;
          end
        end
        ST_VERIFY: begin
          cmp_v_q    <= 1'b1;
          exp_data_q <= pat_q;
          exp_addr_q <= addr_q;
          if (last_addr) begin
            re_q    <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            pat_q  <= pat_d;
          end
        end
        ST_DRAIN: begin
          cmp_v_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Read data returned this cycle belongs to the read issued last cycle.
      if (miscompare) begin
        mismatch_q <= 1'b1;
        if (!mismatch_q) begin
          first_err_q <= exp_addr_q;
        end
        if (err_count_q != '1) begin
          err_count_q <= err_count_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign range_err      = range_err_q;
  assign mismatch       = mismatch_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;
  assign mem_addr       = addr_q;
  assign mem_we         = we_q;
  assign mem_re         = re_q;
  assign mem_wdata      = wdata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ram_sweep_engine.sv
// Bench for ram_sweep_engine: behavioural RAM, reference model of the sweep
// rules, table-driven directed vectors, hand-written corner sequences and a
// randomized phase.
module tb_ram_sweep_engine;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 8;
  localparam int W     = AW + DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [DW-1:0] fill_value = '0;
  logic          busy, done, range_err, mismatch;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_addr, mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  ram_sweep_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .start_addr(start_addr), .end_addr(end_addr), .fill_value(fill_value),
    .busy(busy), .done(done), .range_err(range_err), .mismatch(mismatch),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- behavioural RAM with bench poke port ----------------
  logic [DW-1:0] ram [32];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (poke_en) ram[poke_addr] <= poke_data;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0]  exp_q[$];   // expected writes {addr, data}
  logic [AW-1:0] rd_q[$];    // expected read addresses
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] got);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0h expected none", name, got);
  endtask

  // ---------------- reference model ----------------
  task automatic model_expect(input logic [1:0] m, input int s, input int e, input logic [DW-1:0] v,
                              output int busy_n, output int rerr, output int mis,
                              output int cnt, output int first);
    logic [DW-1:0] want;
    busy_n = 0; rerr = 0; mis = 0; cnt = 0; first = 0;
    if (s > e || e >= DEPTH) begin
      rerr = 1;
    end else begin
      busy_n = m[1] ? (e - s + 2) : (e - s + 1);
      if (m[1]) begin
        for (int k = 0; k <= e - s; k++) begin
          want = m[0] ? DW'(int'(v) + k) : v;
          if (ref_mem[s + k] != want) begin
            if (cnt == 0) first = s + k;
            if (cnt < 255) cnt++;
          end
        end
        mis = (cnt > 0) ? 1 : 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic poke(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = AW'(a); poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic run_op(input string name, input logic [1:0] m, input int s, input int e,
                        input logic [DW-1:0] v, input int glitch, input int exp_busy,
                        input int exp_rerr, input int exp_mis, input int exp_cnt, input int exp_first);
    int busy_cnt, done_at, overlap, c;
    logic [DW-1:0] d;
    exp_q.delete();
    rd_q.delete();
    if (s <= e && e < DEPTH) begin
      for (int k = 0; k <= e - s; k++) begin
        d = m[0] ? DW'(int'(v) + k) : v;
        if (!m[1]) begin
          exp_q.push_back({AW'(s + k), d});
          ref_mem[s + k] = d;
        end else begin
          rd_q.push_back(AW'(s + k));
        end
      end
    end
    @(negedge clk);
    mode = m; start_addr = AW'(s); end_addr = AW'(e); fill_value = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; done_at = 0; overlap = 0; c = 1;
    while (done_at == 0 && c <= 200) begin
      if (busy) busy_cnt++;
      if (mem_we && mem_re) overlap++;
      if (mem_we) begin
        if (exp_q.size() == 0) flag_fail({name, "_extra_write"}, {mem_addr, mem_wdata});
        else check({name, "_write"}, {mem_addr, mem_wdata}, exp_q.pop_front());
      end
      if (mem_re) begin
        if (rd_q.size() == 0) flag_fail({name, "_extra_read"}, mem_addr);
        else check({name, "_read_addr"}, mem_addr, rd_q.pop_front());
      end
      if (done) done_at = c;
      start = (c == glitch);
      if (c == glitch) begin
        mode = 2'($urandom); start_addr = AW'($urandom_range(0, 31));
        end_addr = AW'($urandom_range(0, 31)); fill_value = DW'($urandom);
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check({name, "_done_cycle"}, done_at, exp_busy + 1);
    check({name, "_busy_cycles"}, busy_cnt, exp_busy);
    check({name, "_pending_accesses"}, exp_q.size() + rd_q.size(), 0);
    check({name, "_we_re_overlap"}, overlap, 0);
    check({name, "_range_err"}, range_err, exp_rerr);
    check({name, "_mismatch"}, mismatch, exp_mis);
    check({name, "_err_count"}, err_count, exp_cnt);
    check({name, "_first_err_addr"}, first_err_addr, exp_first);
    check({name, "_done_width"}, {done, busy, mem_we, mem_re}, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]    m;
    int            s;
    int            e;
    logic [DW-1:0] v;
    int            glitch;
    int            busy_n;
    int            rerr;
    int            mis;
    int            cnt;
    int            first;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int bn, re_, mi, cn, fi, gl, s, e;
    logic [1:0] m;
    logic [DW-1:0] v;
    int stray;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    tbl[0]  = '{2'b00, 0, 15, 8'h00, 0, 16, 0, 0, 0, 0};
    tbl[1]  = '{2'b01, 2,  5, 8'hFE, 0,  4, 0, 0, 0, 0};
    tbl[2]  = '{2'b11, 2,  5, 8'hFE, 0,  5, 0, 0, 0, 0};
    tbl[3]  = '{2'b10, 0,  1, 8'h00, 0,  3, 0, 0, 0, 0};
    tbl[4]  = '{2'b10, 0, 15, 8'h00, 0, 17, 0, 1, 3, 2};
    tbl[5]  = '{2'b00, 9,  4, 8'h12, 0,  0, 1, 0, 0, 0};
    tbl[6]  = '{2'b10, 0, 16, 8'h12, 0,  0, 1, 0, 0, 0};
    tbl[7]  = '{2'b00, 7,  7, 8'h3C, 0,  1, 0, 0, 0, 0};
    tbl[8]  = '{2'b10, 7,  7, 8'h3C, 0,  2, 0, 0, 0, 0};
    tbl[9]  = '{2'b10, 7,  7, 8'h3D, 0,  2, 0, 1, 1, 7};
    tbl[10] = '{2'b01, 10, 15, 8'hF0, 0, 6, 0, 0, 0, 0};
    tbl[11] = '{2'b11, 10, 15, 8'hF0, 0, 7, 0, 0, 0, 0};
    tbl[12] = '{2'b01, 0,  5, 8'h10, 2,  6, 0, 0, 0, 0};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, range_err, mismatch, err_count, first_err_addr,
                            mem_addr, mem_we, mem_re, mem_wdata}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].s, tbl[i].e, tbl[i].v, tbl[i].glitch,
             tbl[i].busy_n, tbl[i].rerr, tbl[i].mis, tbl[i].cnt, tbl[i].first);
    end

    // verify-const over a range with two corrupted words
    run_op("aa_fill", 2'b00, 0, 7, 8'hAA, 0, 8, 0, 0, 0, 0);
    poke(3, 8'h55);
    poke(6, 8'h55);
    run_op("aa_verify", 2'b10, 0, 7, 8'hAA, 0, 9, 0, 1, 2, 3);

    // reset during the third write of a 10-word fill
    @(negedge clk);
    mode = 2'b00; start_addr = 5'd4; end_addr = 5'd13; fill_value = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_third_write", {mem_we, mem_addr}, {1'b1, 5'd6});
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs_zero", {busy, done, range_err, mismatch, err_count, first_err_addr,
                                 mem_addr, mem_we, mem_re, mem_wdata}, 32'h0);
    reset = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_we || mem_re || done || busy) stray++;
    end
    check("abort_quiet", stray, 0);
    for (int a = 4; a <= 6; a++) ref_mem[a] = 8'h77;
    run_op("after_abort", 2'b10, 4, 6, 8'h77, 0, 4, 0, 0, 0, 0);

    // randomized sweeps against the reference model
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom_range(0, 3));
      s = $urandom_range(0, 17);
      e = $urandom_range(0, 19);
      v = DW'($urandom);
      if ($urandom_range(0, 3) != 0 && s > e) begin
        int t; t = s; s = e; e = t;
      end
      if (m[1] && s <= e && e < DEPTH && $urandom_range(0, 2) == 0)
        poke($urandom_range(s, e), DW'($urandom));
      model_expect(m, s, e, v, bn, re_, mi, cn, fi);
      gl = (bn > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, bn) : 0;
      run_op($sformatf("rnd%0d", i), m, s, e, v, gl, bn, re_, mi, cn, fi);
    end

    // final RAM contents against the model
    for (int a = 0; a < DEPTH; a++) check($sformatf("ram_word%0d", a), ram[a], ref_mem[a]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_sweep_engine.md
Name: ram_sweep_engine

Overview:
Synthesizable, parametrised successor to the bench-side RAM clear routine. It sweeps an inclusive address range of a single-port synchronous RAM and runs one of four modes: fill with a constant, fill with an incrementing pattern, verify against a constant, or verify against an incrementing pattern. It sits between the control logic (or a bench driver) and the RAM port mux. It gives the design power-on clearing and self-check without hierarchical pokes into memory.

Parameters:
ADDR_WIDTH, 4, RAM address width.
DATA_WIDTH, 8, RAM word width.
DEPTH, 16, number of valid RAM words; must satisfy DEPTH <= 2**ADDR_WIDTH.
CNT_WIDTH, 8, width of the mismatch counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request; sampled only while idle
mode  in  2  00 fill-const, 01 fill-incr, 10 verify-const, 11 verify-incr; latched on start
start_addr  in  ADDR_WIDTH  first address, inclusive; latched on start
end_addr  in  ADDR_WIDTH  last address, inclusive; latched on start
fill_value  in  DATA_WIDTH  constant, or pattern seed; latched on start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at sweep completion
range_err  out  1  sticky; set when a rejected range is requested
mismatch  out  1  sticky; set on any verify miscompare
err_count  out  CNT_WIDTH  miscompares in the last verify; saturates at all-ones
first_err_addr  out  ADDR_WIDTH  address of the first miscompare
mem_addr  out  ADDR_WIDTH  RAM address
mem_we  out  1  RAM write enable
mem_re  out  1  RAM read enable; read data is valid on mem_rdata one cycle later
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (reset==0 at a rising edge): go to IDLE. All outputs are 0, including mem_addr, mem_wdata, err_count, first_err_addr and both sticky flags.
- Reset asserted mid-sweep aborts the sweep on that edge. mem_we and mem_re are 0 from the next cycle. No done pulse is produced.
- States: IDLE, FILL, VERIFY, DRAIN, DONE.
- IDLE accepts start==1:
  - Latch mode, start_addr, end_addr and fill_value.
  - Clear range_err, mismatch, err_count and first_err_addr.
  - If start_addr > end_addr, or end_addr >= DEPTH: set range_err and go to DONE. No memory access occurs.
  - Otherwise go to FILL (mode[1]==0) or VERIFY (mode[1]==1).
- start is ignored while busy.
- Address sequencing:
  - Address a increments by 1 each cycle, from start_addr to end_addr.
  - Offset k = a - start_addr.
  - Expected or write data = fill_value for const modes, or (fill_value + k) mod 2**DATA_WIDTH for incr modes.
- FILL: one write per cycle with mem_we=1, mem_addr=a, mem_wdata=data. Issuing the write to end_addr moves the FSM to DONE.
- VERIFY: one read per cycle with mem_re=1, mem_addr=a. Expected data and address are pipelined one stage.
  - mem_rdata is compared in the cycle after each read.
  - After the read of end_addr, go to DRAIN. DRAIN performs the final compare with no new read.
  - On a miscompare: set mismatch and increment err_count, saturating.
  - On the first miscompare only: capture the pipelined address into first_err_addr.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = 1 in FILL, VERIFY and DRAIN; 0 in IDLE and DONE.
- mem_we and mem_re are never high together. Both are 0 outside FILL and VERIFY.
- Latency for N = end_addr - start_addr + 1:
  - Fill: busy for N cycles, then done.
  - Verify: busy for N+1 cycles, then done.
  - Rejected range: done 1 cycle after the start edge, busy never asserted.
- Single-word range (start_addr == end_addr) is legal: fill takes 1 cycle, verify takes 2.
- Address never wraps, because ranges with end_addr >= DEPTH are rejected. Pattern data wraps modulo 2**DATA_WIDTH.
- Status outputs hold after done until the next accepted start.

Test Plan:
- Reset, then fill-const start=0 end=15 value=00: 16 consecutive writes of 00, busy for 16 cycles, done pulse on the 17th cycle; RAM words 0..15 all read 00.
- Fill-incr start=2 end=5 value=FE: writes 2:FE, 3:FF, 4:00, 5:01; then verify-incr with the same arguments gives mismatch=0, err_count=0, busy for 5 cycles.
- Fill-const start=0 end=7 value=AA, bench corrupts RAM words 3 and 6 to 55, then verify-const value=AA: mismatch=1, err_count=2, first_err_addr=3.
- start_addr=9, end_addr=4 (and separately end_addr=16 with DEPTH=16): range_err=1, done 1 cycle after start, no mem_we or mem_re ever asserted.
- Drive reset low at the 3rd write of a 10-word fill: from the next cycle busy=0 and mem_we=0, no done pulse, only addresses start..start+2 written; a subsequent start operates normally.
- Pulse start again while busy: it is ignored, and the original sweep's range, data and cycle count are unchanged.
